// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port external SRAM arbiter.
// Optional build macro used by the arbiter: SRAM_ARB_ROUND_ROBIN_EN.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } arb_state_e;

    localparam int NUM_PORTS = 2;
    localparam int WAIT_W    = 4;
    localparam int CHIP0     = 0;
    localparam int CHIP1     = 1;
    localparam int LANE_W    = 16;

    // A chip is selected when either of its two byte enables is set.
    function automatic logic [1:0] chip_en(input logic [3:0] be);
        return {|be[3:2], |be[1:0]};
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection between the two SRAM requesters.
// With SRAM_ARB_ROUND_ROBIN_EN a tie goes to prio; otherwise port 0 always wins.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 prio,
    output logic                 valid,
    output logic                 winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (req == 2'b11) begin
            winner = prio;
        end else begin
            winner = req[1];
        end
`else
        winner = ~req[0] & req[1];
`endif
    end

`ifndef SRAM_ARB_ROUND_ROBIN_EN
    logic unused_prio;
    assign unused_prio = prio;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter and setup/strobe/hold sequencer for the 32-bit async SRAM pair.
// Build macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of fixed priority.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no access; pick a winner and latch its request
// ST_SETUP  | address, CE, byte lanes (and write data) settle; strobes high
// ST_STROBE | /OE or /WE low for WAIT_CYCLES cycles; read data taken on last
// ST_HOLD   | strobes high, address/CE/data held; ack to the winner
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [17:0] addr0,
    input  logic [17:0] addr1,
    input  logic [3:0]  be0,
    input  logic [3:0]  be1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  ack,
    output logic [31:0] rdata,
    output logic [17:0] ram_addr,
    input  logic [31:0] ram_data_read,
    output logic [31:0] ram_data_write,
    output logic        ram_data_is_output,
    output logic [1:0]  ram_ce_n,
    output logic [1:0]  ram_ub_n,
    output logic [1:0]  ram_lb_n,
    output logic [1:0]  ram_we_n,
    output logic [1:0]  ram_oe_n
);

    localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [17:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              pick_valid;
    logic              pick_winner;
    logic              prio_sel;
    logic [1:0]        en;
    logic              active;
    logic              strobe;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic prio_q, prio_d;
    assign prio_sel = prio_q;
`else
    assign prio_sel = 1'b0;
`endif

    sram_arb_pick u_pick (
        .req    (req),
        .prio   (prio_sel),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            prio_q  <= prio_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        prio_d  = prio_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_SETUP;
                    port_d  = pick_winner;
                    we_d    = we[pick_winner];
                    addr_d  = pick_winner ? addr1  : addr0;
                    be_d    = pick_winner ? be1    : be0;
                    wdata_d = pick_winner ? wdata1 : wdata0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    prio_d  = ~pick_winner;
`endif
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    // Lanes of unselected chips are floating, so they keep the previous read.
                    if (!we_q) begin
                        if (en[CHIP0]) rdata_d[LANE_W*CHIP0 +: LANE_W] = ram_data_read[LANE_W*CHIP0 +: LANE_W];
                        if (en[CHIP1]) rdata_d[LANE_W*CHIP1 +: LANE_W] = ram_data_read[LANE_W*CHIP1 +: LANE_W];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign en     = chip_en(be_q);
    assign active = (state_q != ST_IDLE);
    assign strobe = (state_q == ST_STROBE);

    assign ram_addr           = addr_q;
    assign ram_data_write     = wdata_q;
    assign ram_data_is_output = active & we_q;
    assign ram_ce_n           = active ? ~en : 2'b11;
    assign ram_lb_n           = active ? ~{be_q[2], be_q[0]} : 2'b11;
    assign ram_ub_n           = active ? ~{be_q[3], be_q[1]} : 2'b11;
    assign ram_oe_n           = (strobe && !we_q) ? ~en : 2'b11;
    assign ram_we_n           = (strobe &&  we_q) ? ~en : 2'b11;
    assign ack                = (state_q == ST_HOLD) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    assign rdata              = rdata_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter and cycle sequencer for the board's external asynchronous SRAM pair: two 256K×16 chips forming one 32-bit word. It sits between `system` and the SRAM pins and shares the SRAM between port 0 (68k bus bridge) and port 1 (UART boot loader / DMA). It grants one requester at a time and runs a fixed setup/strobe/hold sequence on the per-chip control lines. `top` merges the per-chip /WE and /OE onto the board's common pins.

## Interface
- `WAIT_CYCLES`, default 2: strobe (/OE or /WE low) length in clk cycles; legal range 1..15.
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req[1:0]` in 2: per-port access request; held high until that port's ack.
- `we[1:0]` in 2: per-port write (1) / read (0).
- `addr0`, `addr1` in 18 each: 32-bit word address.
- `be0`, `be1` in 4 each: byte enables; [1:0] → chip0 (data[15:0]), [3:2] → chip1 (data[31:16]).
- `wdata0`, `wdata1` in 32 each: write data.
- `ack[1:0]` out 2: one-cycle completion pulse per port.
- `rdata` out 32: read data, valid in ack cycle and held until next read completes.
- `ram_addr` out 18; `ram_data_read` in 32; `ram_data_write` out 32; `ram_data_is_output` out 1.
- `ram_ce_n`, `ram_ub_n`, `ram_lb_n`, `ram_we_n`, `ram_oe_n` out 2 each: per-chip active-low controls, index = chip.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: if any `req` high, pick winner → SETUP, latch winner's addr/be/we/wdata; else stay.
- SETUP (1 cycle): `ram_addr` driven; `ram_ce_n[i]`=0 iff any be bit of chip i set; ub/lb from be; for writes `ram_data_is_output`=1 and data driven. /WE and /OE high.
- STROBE (`WAIT_CYCLES` cycles, down-counter): reads assert `ram_oe_n` on enabled chips; writes assert `ram_we_n` on enabled chips. On the last STROBE cycle the read data is registered into `rdata`; lanes of disabled chips keep their old value.
- HOLD (1 cycle): strobes high; address, CE and write data still driven; `ack[winner]`=1 → IDLE.
- Requester rule: `req` still high in the cycle after ack counts as a new request.
- be = 0: full sequence runs with no CE asserted; ack still issued.
- Losing requester waits; its req/inputs must stay stable.

## Timing
- Reset values: all `_n` outputs 2'b11, `ram_data_is_output`=0, `ram_addr`=0, `ram_data_write`=0, `ack`=0, `rdata`=0, FSM IDLE, round-robin pointer = port 0.
- req sampled high at edge N in IDLE → SETUP in cycle N+1, STROBE N+2..N+1+W, HOLD/ack in cycle N+2+W, IDLE at N+3+W.
- Back-to-back accesses: one IDLE cycle between transactions; throughput one access per W+3 cycles.
- `ram_data_is_output` never 1 while any `ram_oe_n` bit is 0.
- Reset mid-transaction: next edge forces reset values, no ack issued, transaction abandoned.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined: on a simultaneous request, the port that did not win last is granted. Pointer updates at grant.
- Undefined: fixed priority, port 0 always wins; pointer logic absent.

## Structure
- Package `sram_arb_pkg`: FSM state enum, `NUM_PORTS`=2, `WAIT_W`=4 (counter width), chip/lane index constants.
- Sub-module `sram_arb_pick`: combinational winner selection from `req` plus the last-grant pointer. The pointer input is ignored without the macro.

## Test plan
- Port0 write addr 18'h00010, be 4'hF, data 32'hDEADBEEF, W=2 → SETUP 1 cycle, both `ram_we_n`=00 for 2 cycles, `ack[0]` at 5th cycle after req; data driven throughout.
- Port1 read of 18'h00010 (SRAM model) → `rdata`=32'hDEADBEEF in `ack[1]` cycle; `ram_data_is_output`=0 throughout.
- Port0 write be 4'b0100, data 32'h00AA0000 → `ram_ce_n`=2'b01, `ram_lb_n`=2'b01, `ram_ub_n`=2'b11; readback 32'hDEAABEEF.
- Both req high continuously, macro defined → grants alternate 0,1,0,1. Macro undefined → port 0 only; port 1 starves until port 0 drops req.
- `reset_n` low during STROBE of a write → next cycle all controls 11, `ram_data_is_output`=0, no ack; after release a new request completes normally.
